// File: rtl/zdraw_scheduler.sv
// Draw-core sequencer/arbiter: power-on draw list, then prioritised redraws.
// Optional draw-done watchdog is compiled in with `define ZDRAW_SCHED_WDOG_EN.
module zdraw_scheduler #(
  parameter int unsigned REFRESH_DIV = 5_000_000,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter int unsigned WDOG_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  iMode,
  input  logic        iData_Update,
  input  logic [31:0] iPulse_Counter,
  input  logic [31:0] iPulseCounter_Accumulated,
  output logic        oCore_En,
  output logic [3:0]  oCore_Cmd,
  output logic [31:0] oCore_Data1,
  input  logic        iCore_Done,
  output logic        oBusy,
  output logic        oInit_Done,
  output logic        oWdog_Err
);
  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int F_ACC = 0, F_WAVE = 1, F_RTC = 2, F_MODE = 3, F_PULSE = 4;

  typedef enum logic [2:0] {
    S_START, S_INIT_ISSUE, S_INIT_WAIT, S_IDLE, S_ISSUE, S_WAIT, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          core_en_q, core_en_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   data_q, data_d;
  logic          init_done_q, init_done_d;
  logic [1:0]    step_q, step_d;
  logic [4:0]    pend_q, pend_d, pset, sel;
  logic [31:0]   shadow_q, shadow_d;
  logic [1:0]    mode_q, mode_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_seen_q, done_seen_d;
  logic          run, tick, issuing, init_end, done_now, wdog_to;
  logic [3:0]    icmd;
  logic [31:0]   idata;

  assign done_now = core_en_q && (iCore_Done || done_seen_q);
  assign issuing  = en && (state_q == S_IDLE) && (|pend_q);
  assign init_end = en && (state_q == S_GAP) && !init_done_q && (step_q == 2'd3);

  // Refresh timer only runs once the power-on list is finished.
  assign run  = en && init_done_q && (state_q inside {S_IDLE, S_ISSUE, S_WAIT, S_GAP});
  assign tick = run && (timer_q == TW'(REFRESH_DIV - 1));
  assign timer_d = run ? (tick ? '0 : timer_q + TW'(1)) : timer_q;

  always_comb begin
    sel = '0;
    if      (pend_q[F_PULSE]) sel[F_PULSE] = 1'b1;
    else if (pend_q[F_MODE])  sel[F_MODE]  = 1'b1;
    else if (pend_q[F_RTC])   sel[F_RTC]   = 1'b1;
    else if (pend_q[F_WAVE])  sel[F_WAVE]  = 1'b1;
    else if (pend_q[F_ACC])   sel[F_ACC]   = 1'b1;
  end

  // Set wins over clear; MODE compares against the mode being issued this edge.
  always_comb begin
    pset          = '0;
    pset[F_PULSE] = iData_Update;
    pset[F_MODE]  = (iMode != mode_q) && !(issuing && sel[F_MODE]);
    pset[F_RTC]   = tick;
    pset[F_WAVE]  = tick;
    pset[F_ACC]   = tick;
    pend_d        = (pend_q & ~(issuing ? sel : 5'b0)) | pset;
    if (init_end) pend_d[F_MODE] = 1'b1;
  end

  assign shadow_d = iData_Update ? iPulse_Counter : shadow_q;

  always_comb begin
    icmd  = 4'd4;
    idata = 32'h0;
    case (step_q)
      2'd0:    begin icmd = 4'd0; idata = {16'h0, BG_COLOR}; end
      2'd1:    icmd = 4'd1;
      default: icmd = 4'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    core_en_d   = core_en_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    mode_d      = mode_q;
    done_seen_d = done_seen_q | (core_en_q & iCore_Done);
    if (en) begin
      case (state_q)
        S_START: begin
          state_d   = S_INIT_ISSUE;
          core_en_d = 1'b1;
          cmd_d     = icmd;
          data_d    = idata;
        end
        S_INIT_ISSUE, S_INIT_WAIT, S_ISSUE, S_WAIT: begin
          if (done_now || wdog_to) begin
            state_d     = S_GAP;
            core_en_d   = 1'b0;
            done_seen_d = 1'b0;
            if (!init_done_q) step_d = step_q + 2'd1;
          end else if (state_q == S_INIT_ISSUE) begin
            state_d = S_INIT_WAIT;
          end else if (state_q == S_ISSUE) begin
            state_d = S_WAIT;
          end
        end
        S_GAP: begin
          if (init_done_q || init_end) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d   = S_INIT_ISSUE;
            core_en_d = 1'b1;
            cmd_d     = icmd;
            data_d    = idata;
          end
        end
        S_IDLE: begin
          if (issuing) begin
            state_d   = S_ISSUE;
            core_en_d = 1'b1;
            data_d    = 32'h0;
            if (sel[F_PULSE]) begin
              cmd_d  = 4'd5;
              data_d = shadow_q;
            end else if (sel[F_MODE]) begin
              cmd_d  = 4'd7;
              data_d = {30'h0, iMode};
              mode_d = iMode;
            end else if (sel[F_RTC]) begin
              cmd_d = 4'd2;
            end else if (sel[F_WAVE]) begin
              cmd_d = 4'd3;
            end else begin
              cmd_d  = 4'd8;
              data_d = iPulseCounter_Accumulated;
            end
          end
        end
        default: state_d = S_START;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_START;
      core_en_q   <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      step_q      <= '0;
      pend_q      <= '0;
      shadow_q    <= '0;
      mode_q      <= '0;
      timer_q     <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_en_q   <= core_en_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      mode_q      <= mode_d;
      timer_q     <= timer_d;
      done_seen_q <= done_seen_d;
    end
  end

`ifdef ZDRAW_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          werr_q;
  logic          waiting;

  assign waiting = (state_q == S_WAIT) || (state_q == S_INIT_WAIT);
  assign wdog_to = en && waiting && (wdog_q == WW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (en) wdog_d = (waiting && !wdog_to) ? wdog_q + WW'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      werr_q <= werr_q | wdog_to;
    end
  end

  assign oWdog_Err = werr_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wdog_to     = 1'b0;
  assign oWdog_Err   = 1'b0;
`endif

  assign oCore_En    = core_en_q;
  assign oCore_Cmd   = cmd_q;
  assign oCore_Data1 = data_q;
  assign oBusy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign oInit_Done  = init_done_q;
endmodule

// File: tb/tb_zdraw_scheduler.sv
// Directed bench for zdraw_scheduler: init list, priority order, shadow refresh,
// enable freeze, optional watchdog, async reset mid-command.
module tb_zdraw_scheduler;
  localparam int          DIV = 64;
  localparam logic [15:0] BG  = 16'hBEEF;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [1:0]  iMode = 2'd0;
  logic        upd = 1'b0;
  logic [31:0] pcnt = '0, acc = 32'h0000_ACC1;
  logic        core_en, busy, idone, werr, done;
  logic [3:0]  cmd;
  logic [31:0] d1;
  logic        auto_done = 1'b0, man_done = 1'b0, prev_en = 1'b0;
  bit          auto_on = 1'b1;
  int          cnt = 0, cyc = 0, t0 = 0, qb = 0, k = 0;
  int          checks = 0, failures = 0;

  typedef struct { logic [3:0] c; logic [31:0] d; int at; } ent_t;
  ent_t q[$];

  assign done = auto_done | man_done;

  zdraw_scheduler #(.REFRESH_DIV(DIV), .BG_COLOR(BG), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .en(en), .iMode(iMode), .iData_Update(upd),
    .iPulse_Counter(pcnt), .iPulseCounter_Accumulated(acc),
    .oCore_En(core_en), .oCore_Cmd(cmd), .oCore_Data1(d1), .iCore_Done(done),
    .oBusy(busy), .oInit_Done(idone), .oWdog_Err(werr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ent_t mk(logic [3:0] c, logic [31:0] d, int at);
    ent_t r;
    r.c = c; r.d = d; r.at = at;
    return r;
  endfunction

  // Command log plus a core model that answers done on the third cycle of En.
  always @(negedge clk) begin
    if (core_en && !prev_en) q.push_back(mk(cmd, d1, cyc));
    prev_en <= core_en;
    if (core_en && auto_on) begin
      cnt       <= cnt + 1;
      auto_done <= (cnt + 1 == 3);
    end else begin
      cnt       <= 0;
      auto_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ent(input int i, input logic [3:0] c, input logic [31:0] d, input string tag);
    ent_t e;
    if (i < q.size()) e = q[i];
    else e = mk('x, 'x, -1);
    chk({tag, "_cmd"}, {28'h0, e.c}, {28'h0, c});
    chk({tag, "_data"}, e.d, d);
  endtask

  task automatic wait_t(input int tt);
    int n = 0;
    while ((cyc - t0) < tt && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_q(input int n, input string tag);
    int b = 0;
    while (q.size() < n && b < 300) begin
      @(negedge clk); #1;
      b++;
    end
    chk(tag, {31'h0, q.size() >= n}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", {31'h0, core_en}, 0);
    chk("rst_cmd", {28'h0, cmd}, 0);
    chk("rst_data", d1, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_idone", {31'h0, idone}, 0);
    chk("rst_werr", {31'h0, werr}, 0);
    rst = 1'b0;

    k = 0;
    while (!idone && k < 500) begin @(negedge clk); k++; end
    chk("init_done", {31'h0, idone}, 1);
    t0 = cyc;
    wait_q(4, "init_count");
    chk_ent(0, 4'd0, {16'h0, BG}, "init0");
    chk_ent(1, 4'd1, 32'h0, "init1");
    chk_ent(2, 4'd4, 32'h0, "init2");
    chk_ent(3, 4'd7, 32'h0, "mode0");
    chk("init_gap", {31'h0, (q[1].at - q[0].at) >= 4 && (q[2].at - q[1].at) >= 4}, 1);
    chk("mode0_at", q[3].at - t0, 1);

    // Single pulse update.
    wait_t(10); upd = 1'b1; pcnt = 32'h0000_1234;
    wait_t(11); upd = 1'b0;
    wait_t(12);
    chk("pulse_en", {31'h0, core_en}, 1);
    chk("pulse_cmd", {28'h0, cmd}, 5);
    chk("pulse_data", d1, 32'h1234);
    chk("pulse_busy", {31'h0, busy}, 1);

    // Pulse, mode change and refresh tick all on the same cycle.
    wait_t(DIV - 1); upd = 1'b1; pcnt = 32'hA; iMode = 2'd2;
    wait_t(DIV); upd = 1'b0;
    wait_q(10, "tick_count");
    chk_ent(5, 4'd5, 32'hA, "prio0");
    chk_ent(6, 4'd7, 32'h2, "prio1");
    chk_ent(7, 4'd2, 32'h0, "prio2");
    chk_ent(8, 4'd3, 32'h0, "prio3");
    chk_ent(9, 4'd8, 32'h0000_ACC1, "prio4");
    chk("prio0_at", q[5].at - t0, 65);

    // Second update while the first cmd 5 is in flight.
    wait_t(100); upd = 1'b1; pcnt = 32'hA;
    wait_t(101); upd = 1'b0;
    wait_t(103); upd = 1'b1; pcnt = 32'hB;
    wait_t(104); upd = 1'b0;
    chk("inflight_en", {31'h0, core_en}, 1);
    chk("inflight_data", d1, 32'hA);
    wait_q(12, "reissue_count");
    chk_ent(10, 4'd5, 32'hA, "first5");
    chk_ent(11, 4'd5, 32'hB, "second5");
    chk("second5_at", q[11].at - t0, 107);

    // Freeze with en=0 while waiting; done arrives during the freeze.
    wait_t(112); auto_on = 1'b0;
    wait_t(115); upd = 1'b1; pcnt = 32'h77;
    wait_t(116); upd = 1'b0;
    wait_t(118); en = 1'b0;
    wait_t(120); man_done = 1'b1;
    wait_t(121); man_done = 1'b0;
    wait_t(125); chk("frozen_en", {31'h0, core_en}, 1);
    wait_t(128); chk("frozen_en_last", {31'h0, core_en}, 1);
    en = 1'b1; auto_on = 1'b1;
    wait_t(129); chk("resume_fall", {31'h0, core_en}, 0);
    wait_t(140); acc = 32'h0000_ACC2;
    wait_q(16, "resume_count");
    chk_ent(12, 4'd5, 32'h77, "frozen5");
    chk_ent(13, 4'd2, 32'h0, "late_rtc");
    chk("late_rtc_at", q[13].at - t0, 139);
    chk_ent(14, 4'd3, 32'h0, "late_wave");
    chk_ent(15, 4'd8, 32'h0000_ACC2, "late_acc");

    // Core that never answers.
    wait_t(155); auto_on = 1'b0;
    wait_t(160); upd = 1'b1; pcnt = 32'h55;
    wait_t(161); upd = 1'b0;
`ifdef ZDRAW_SCHED_WDOG_EN
    wait_t(178); chk("wdog_hold", {31'h0, core_en}, 1);
    wait_t(179); chk("wdog_fall", {31'h0, core_en}, 0);
    chk("wdog_err", {31'h0, werr}, 1);
    wait_t(185); upd = 1'b1; pcnt = 32'h66;
    wait_t(186); upd = 1'b0;
`else
    wait_t(179); chk("nowdog_hold", {31'h0, core_en}, 1);
    chk("nowdog_err", {31'h0, werr}, 0);
`endif
    wait_t(189); chk("prerst_en", {31'h0, core_en}, 1);
    qb = q.size();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_en", {31'h0, core_en}, 0);
    chk("rst_mid_busy", {31'h0, busy}, 0);
    chk("rst_mid_idone", {31'h0, idone}, 0);
    chk("rst_mid_werr", {31'h0, werr}, 0);
    auto_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_q(qb + 1, "restart_count");
    chk_ent(qb, 4'd0, {16'h0, BG}, "restart0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
